nios_system_nios2_gen2_0_dct_sequencer: RTL and testbench

NIOS_SYSTEM_NIOS2_GEN2_0_DCT_SEQUENCER -- requirements
Module: nios_system_nios2_gen2_0_dct_sequencer

---
 rtl/nios_system_dct_pkg.sv | 20 ++
 rtl/nios_system_dct_out_slot.sv | 58 +++++
 rtl/nios_system_nios2_gen2_0_dct_sequencer.sv | 171 +++++++++++++++++
 tb/tb_nios_system_nios2_gen2_0_dct_sequencer.sv | 328 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/nios_system_dct_pkg.sv
// Shared definitions for the DCT trace sequencer: FSM states and default
// packing geometry.
package nios_system_dct_pkg;

  localparam int ITEM_W_DEF         = 10;
  localparam int ITEMS_PER_WORD_DEF = 3;

  // dct_count is exposed zero-extended to this width
  localparam int COUNT_W            = 4;
  // word_count carries 1..ITEMS_PER_WORD
  localparam int WORD_COUNT_W       = 2;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FILL  = 2'd1,
    ST_FLUSH = 2'd2,
    ST_DONE  = 2'd3
  } dct_state_e;

endpackage

// File: rtl/nios_system_dct_out_slot.sv
// Single-entry output register: holds a packed word until the sink takes it.
// slot_free tells the producer a load this cycle will not overwrite a pending
// word (slot empty, or being drained at this edge).
module nios_system_dct_out_slot #(
  parameter int DATA_W = 30,
  parameter int CNT_W  = 2
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              load,
  input  logic [DATA_W-1:0] load_data,
  input  logic [CNT_W-1:0]  load_count,
  input  logic              out_ready,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  output logic [CNT_W-1:0]  out_count,
  output logic              slot_free
);

  logic              valid_q, valid_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic [CNT_W-1:0]  count_q, count_d;

  assign slot_free = !valid_q || out_ready;

  // drain on handshake; a load in the same cycle takes precedence
  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    count_d = count_q;
    if (valid_q && out_ready) begin
      valid_d = 1'b0;
    end
    if (load) begin
      valid_d = 1'b1;
      data_d  = load_data;
      count_d = load_count;
    end
  end

  // slot registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      count_q <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
      count_q <= count_d;
    end
  end

  assign out_valid = valid_q;
  assign out_data  = data_q;
  assign out_count = count_q;

endmodule

// File: rtl/nios_system_nios2_gen2_0_dct_sequencer.sv
// DCT data-trace sequencer: packs trace items into words, hands full words to
// the output slot, and on flush drains the partial word before ending.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_IDLE  | capture off, buffer empty
// ST_FILL  | packing items; a full buffer waits here for the slot
// ST_FLUSH | no new items; partial word pushed out, slot drained
// ST_DONE  | test ended; sticky until reset
module nios_system_nios2_gen2_0_dct_sequencer
  import nios_system_dct_pkg::*;
#(
  parameter int ITEM_W         = ITEM_W_DEF,
  parameter int ITEMS_PER_WORD = ITEMS_PER_WORD_DEF
) (
  input  logic                               clk,
  input  logic                               reset_n,
  input  logic                               enable,
  input  logic                               item_valid,
  input  logic [ITEM_W-1:0]                  item_data,
  output logic                               item_ready,
  input  logic                               flush_req,
  output logic                               word_valid,
  input  logic                               word_ready,
  output logic [ITEM_W*ITEMS_PER_WORD-1:0]   word_data,
  output logic [WORD_COUNT_W-1:0]            word_count,
  output logic [ITEM_W*ITEMS_PER_WORD-1:0]   dct_buffer,
  output logic [COUNT_W-1:0]                 dct_count,
  output logic                               test_ending,
  output logic                               test_has_ended
);

  localparam int                 WORD_W   = ITEM_W * ITEMS_PER_WORD;
  localparam logic [COUNT_W-1:0] FULL_CNT = COUNT_W'(ITEMS_PER_WORD);

  dct_state_e              state_q, state_d;
  logic [WORD_W-1:0]       buf_q, buf_d, base_buf;
  logic [COUNT_W-1:0]      cnt_q, cnt_d, base_cnt;
  logic                    test_ending_q, test_ending_d;
  logic                    test_has_ended_q, test_has_ended_d;
  logic                    item_ready_c, accept;
  logic                    slot_load, slot_free, slot_valid;
  logic [WORD_W-1:0]       slot_data;
  logic [WORD_COUNT_W-1:0] slot_count;

  // next state, buffer packing and slot load decisions
  always_comb begin
    state_d      = state_q;
    buf_d        = buf_q;
    cnt_d        = cnt_q;
    base_buf     = buf_q;
    base_cnt     = cnt_q;
    slot_load    = 1'b0;
    slot_data    = buf_q;
    slot_count   = '0;
    item_ready_c = 1'b0;
    accept       = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (flush_req) begin
          state_d = ST_FLUSH;
        end else if (enable) begin
          state_d = ST_FILL;
        end
      end

      ST_FILL: begin
        // a held full word moves out as soon as the slot frees, which also
        // reopens the buffer for an item in the same cycle
        if (cnt_q == FULL_CNT && slot_free) begin
          slot_load  = 1'b1;
          slot_data  = buf_q;
          slot_count = WORD_COUNT_W'(FULL_CNT);
          base_buf   = '0;
          base_cnt   = '0;
        end
        item_ready_c = enable && (base_cnt < FULL_CNT);
        accept       = item_valid && item_ready_c;
        buf_d        = base_buf;
        cnt_d        = base_cnt;
        if (accept) begin
          for (int k = 0; k < ITEMS_PER_WORD; k++) begin
            if (base_cnt == COUNT_W'(k)) begin
              buf_d[ITEM_W*k +: ITEM_W] = item_data;
            end
          end
          cnt_d = base_cnt + 1'b1;
          // completing item bypasses the hold when the slot can take it now
          if (cnt_d == FULL_CNT && slot_free && !slot_load) begin
            slot_load  = 1'b1;
            slot_data  = buf_d;
            slot_count = WORD_COUNT_W'(FULL_CNT);
            buf_d      = '0;
            cnt_d      = '0;
          end
        end
        if (flush_req) begin
          state_d = ST_FLUSH;
        end else if (!enable && cnt_q == '0) begin
          state_d = ST_IDLE;
        end
      end

      ST_FLUSH: begin
        if (cnt_q != '0 && slot_free) begin
          slot_load  = 1'b1;
          slot_data  = buf_q;
          slot_count = WORD_COUNT_W'(cnt_q);
          buf_d      = '0;
          cnt_d      = '0;
        end
        if (cnt_q == '0 && !slot_valid) begin
          state_d = ST_DONE;
        end
      end

      ST_DONE: begin
        state_d = ST_DONE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    test_ending_d    = (state_d == ST_FLUSH);
    test_has_ended_d = test_has_ended_q || (state_d == ST_DONE);
  end

  // state and packing registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q          <= ST_IDLE;
      buf_q            <= '0;
      cnt_q            <= '0;
      test_ending_q    <= 1'b0;
      test_has_ended_q <= 1'b0;
    end else begin
      state_q          <= state_d;
      buf_q            <= buf_d;
      cnt_q            <= cnt_d;
      test_ending_q    <= test_ending_d;
      test_has_ended_q <= test_has_ended_d;
    end
  end

  nios_system_dct_out_slot #(
    .DATA_W (WORD_W),
    .CNT_W  (WORD_COUNT_W)
  ) u_out_slot (
    .clk        (clk),
    .reset_n    (reset_n),
    .load       (slot_load),
    .load_data  (slot_data),
    .load_count (slot_count),
    .out_ready  (word_ready),
    .out_valid  (slot_valid),
    .out_data   (word_data),
    .out_count  (word_count),
    .slot_free  (slot_free)
  );

  assign item_ready     = item_ready_c;
  assign word_valid     = slot_valid;
  assign dct_buffer     = buf_q;
  assign dct_count      = cnt_q;
  assign test_ending    = test_ending_q;
  assign test_has_ended = test_has_ended_q;

endmodule

// File: tb/tb_nios_system_nios2_gen2_0_dct_sequencer.sv
// Bench for the DCT trace sequencer: directed scenarios plus a random run.
// Accepted items feed a packing model; expected words go into a queue that a
// monitor pops whenever the DUT hands a word to the sink.
module tb_nios_system_nios2_gen2_0_dct_sequencer;

  localparam int ITEM_W = 10;
  localparam int NITEMS = 3;
  localparam int WORD_W = ITEM_W * NITEMS;

  logic              clk = 1'b0;
  logic              reset_n = 1'b0;
  logic              enable = 1'b0;
  logic              item_valid = 1'b0;
  logic [ITEM_W-1:0] item_data = '0;
  logic              flush_req = 1'b0;
  logic              word_ready = 1'b0;
  logic              item_ready;
  logic              word_valid;
  logic [WORD_W-1:0] word_data;
  logic [1:0]        word_count;
  logic [WORD_W-1:0] dct_buffer;
  logic [3:0]        dct_count;
  logic              test_ending;
  logic              test_has_ended;

  nios_system_nios2_gen2_0_dct_sequencer #(
    .ITEM_W         (ITEM_W),
    .ITEMS_PER_WORD (NITEMS)
  ) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .enable         (enable),
    .item_valid     (item_valid),
    .item_data      (item_data),
    .item_ready     (item_ready),
    .flush_req      (flush_req),
    .word_valid     (word_valid),
    .word_ready     (word_ready),
    .word_data      (word_data),
    .word_count     (word_count),
    .dct_buffer     (dct_buffer),
    .dct_count      (dct_count),
    .test_ending    (test_ending),
    .test_has_ended (test_has_ended)
  );

  initial forever #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // reference model state
  logic [ITEM_W-1:0] cur_q[$];
  logic [WORD_W+1:0] exp_q[$];
  bit                m_flushing = 1'b0;
  bit                stall_prev = 1'b0;
  logic [WORD_W-1:0] prev_data = '0;
  logic [1:0]        prev_count = '0;
  logic [WORD_W-1:0] last_data = '0;
  logic [1:0]        last_count = '0;
  int                words_seen = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // item i of a word sits at bit offset ITEM_W*i; returns {count, data}
  function automatic logic [WORD_W+1:0] pack_word(input logic [ITEM_W-1:0] items[$]);
    logic [WORD_W-1:0] w;
    w = '0;
    for (int i = 0; i < items.size(); i++) begin
      w = w | (WORD_W'(items[i]) << (ITEM_W * i));
    end
    return {2'(items.size()), w};
  endfunction

  // monitor: scoreboard pop on word handshake, model update on item handshake
  always @(negedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cur_q.delete();
      exp_q.delete();
      m_flushing = 1'b0;
      stall_prev = 1'b0;
    end else begin
      if (stall_prev) begin
        check("hold_stable", {word_valid, word_count, word_data}, {1'b1, prev_count, prev_data});
      end
      stall_prev = word_valid && !word_ready;
      prev_data  = word_data;
      prev_count = word_count;
      if (word_valid && word_ready) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_word: got %0h count %0d expected none", word_data, word_count);
        end else begin
          check("word", {word_count, word_data}, exp_q.pop_front());
        end
        words_seen++;
        last_data  = word_data;
        last_count = word_count;
      end
      if (item_valid && item_ready) begin
        if (m_flushing) begin
          n_checks++;
          n_fail++;
          $display("FAIL accept_after_flush: got item_ready 1 expected 0");
        end else begin
          cur_q.push_back(item_data);
          if (cur_q.size() == NITEMS) begin
            exp_q.push_back(pack_word(cur_q));
            cur_q.delete();
          end
        end
      end
      if (flush_req && !m_flushing) begin
        m_flushing = 1'b1;
        if (cur_q.size() > 0) begin
          exp_q.push_back(pack_word(cur_q));
          cur_q.delete();
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    reset_n    = 1'b0;
    enable     = 1'b0;
    item_valid = 1'b0;
    flush_req  = 1'b0;
    word_ready = 1'b0;
    item_data  = '0;
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
  endtask

  task automatic wait_drain(input string name);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || word_valid) && n < 100) begin
      tick();
      n++;
    end
    check({name, "_drain"}, exp_q.size(), 0);
  endtask

  task automatic wait_ended(input string name);
    int n;
    n = 0;
    while (!test_has_ended && n < 100) begin
      tick();
      n++;
    end
    check({name, "_ended"}, test_has_ended, 1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    int acc;

    // reset values, sampled while reset is held
    reset_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_word_valid", word_valid, 0);
    check("rst_word_data", word_data, 0);
    check("rst_word_count", word_count, 0);
    check("rst_dct_buffer", dct_buffer, 0);
    check("rst_dct_count", dct_count, 0);
    check("rst_item_ready", item_ready, 0);
    check("rst_test_ending", test_ending, 0);
    check("rst_test_has_ended", test_has_ended, 0);

    // three items back to back with the sink always ready
    apply_reset();
    enable = 1'b1; word_ready = 1'b1;
    tick();
    base = words_seen;
    for (int i = 1; i <= 3; i++) begin
      item_valid = 1'b1;
      item_data  = ITEM_W'(i);
      @(negedge clk);
      check("r021_ready", item_ready, 1);
      tick();
    end
    item_valid = 1'b0;
    wait_drain("r021");
    check("r021_nwords", words_seen - base, 1);
    check("r021_data", last_data, 30'h00300801);
    check("r021_count", last_count, 3);

    // sink stalled: one word in slot, second word held in the buffer
    apply_reset();
    enable = 1'b1; word_ready = 1'b0;
    tick();
    base = words_seen;
    acc  = 0;
    for (int i = 0; i < 7; i++) begin
      item_valid = 1'b1;
      item_data  = ITEM_W'($urandom);
      @(negedge clk);
      if (i == 6) check("r022_ready_7th", item_ready, 0);
      if (item_ready) acc++;
      tick();
    end
    item_valid = 1'b0;
    check("r022_accepted", acc, 6);
    check("r022_dct_count", dct_count, 3);
    check("r022_word_valid", word_valid, 1);
    check("r022_nwords_stalled", words_seen - base, 0);
    word_ready = 1'b1;
    wait_drain("r022");
    check("r022_nwords", words_seen - base, 2);

    // partial word flushed
    apply_reset();
    enable = 1'b1; word_ready = 1'b1;
    tick();
    base = words_seen;
    item_valid = 1'b1; item_data = 10'h155; tick();
    item_data = 10'h2AA; tick();
    item_valid = 1'b0; flush_req = 1'b1; tick();
    flush_req = 1'b0;
    check("r023_test_ending", test_ending, 1);
    wait_ended("r023");
    check("r023_ending_clear", test_ending, 0);
    check("r023_nwords", words_seen - base, 1);
    check("r023_data", last_data, 30'h000AA955);
    check("r023_count", last_count, 2);

    // flush with nothing buffered
    apply_reset();
    base = words_seen;
    flush_req = 1'b1; tick();
    flush_req = 1'b0;
    check("r024_flush_ending", test_ending, 1);
    check("r024_flush_not_ended", test_has_ended, 0);
    tick();
    check("r024_done_ending", test_ending, 0);
    check("r024_done_ended", test_has_ended, 1);
    enable = 1'b1; item_valid = 1'b1; word_ready = 1'b1;
    @(negedge clk);
    check("r024_item_ready", item_ready, 0);
    repeat (3) tick();
    item_valid = 1'b0;
    check("r024_dct_count", dct_count, 0);
    check("r024_nwords", words_seen - base, 0);
    check("r024_still_ended", test_has_ended, 1);

    // reset mid-word with a word pending
    apply_reset();
    enable = 1'b1; word_ready = 1'b0;
    tick();
    for (int i = 0; i < 5; i++) begin
      item_valid = 1'b1;
      item_data  = ITEM_W'($urandom);
      tick();
    end
    item_valid = 1'b0;
    @(negedge clk);
    check("r025_pre_count", dct_count, 2);
    check("r025_pre_valid", word_valid, 1);
    #1 reset_n = 1'b0;
    #1;
    check("r025_word_valid", word_valid, 0);
    check("r025_word_data", word_data, 0);
    check("r025_word_count", word_count, 0);
    check("r025_dct_count", dct_count, 0);
    check("r025_dct_buffer", dct_buffer, 0);
    check("r025_item_ready", item_ready, 0);
    #1 reset_n = 1'b1;
    base = words_seen;
    word_ready = 1'b1;
    repeat (10) tick();
    check("r025_nwords_after", words_seen - base, 0);

    // third item and flush in the same cycle
    apply_reset();
    enable = 1'b1; word_ready = 1'b1;
    tick();
    base = words_seen;
    item_valid = 1'b1; item_data = 10'h3FF; tick();
    item_data = 10'h000; tick();
    item_data = 10'h201; flush_req = 1'b1; tick();
    item_valid = 1'b0; flush_req = 1'b0;
    wait_ended("r026");
    check("r026_nwords", words_seen - base, 1);
    check("r026_data", last_data, 30'h201003FF);
    check("r026_count", last_count, 3);

    // random traffic, then flush
    apply_reset();
    base = words_seen;
    for (int c = 0; c < 3000; c++) begin
      enable     = ($urandom_range(0, 7) != 0);
      item_valid = ($urandom_range(0, 9) < 7);
      item_data  = ITEM_W'($urandom);
      word_ready = ($urandom_range(0, 9) < 6);
      tick();
    end
    item_valid = 1'b0; word_ready = 1'b1; flush_req = 1'b1;
    tick();
    flush_req = 1'b0;
    wait_ended("rand");
    wait_drain("rand");
    check("rand_words_emitted", (words_seen - base) > 100, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
